// File: rtl/tx_scheduler_if.sv
// Word-table read port and word-transmitter start/busy/done handshake used by tx_scheduler.
interface tx_scheduler_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IDX_W  = 4
);
   logic [IDX_W-1:0]  rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] tx_data;
   logic              tx_start;
   logic              tx_busy;
   logic              tx_done;

   modport master (
      output rd_addr, tx_data, tx_start,
      input  rd_data, tx_busy, tx_done
   );

   modport slave (
      input  rd_addr, tx_data, tx_start,
      output rd_data, tx_busy, tx_done
   );
endinterface

// File: rtl/tx_scheduler.sv
// Frame-level transmit scheduler: arbitrates manual/logic/auto requests and sequences NWORDS words
// into the word transmitter. Optional auto-repeat timer enabled by defining TX_AUTO_REPEAT_EN.
module tx_scheduler #(
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned NWORDS         = 16,
   parameter int unsigned IDX_W          = 4,
   parameter int unsigned GAP_CYCLES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65536,
   parameter int unsigned REPEAT_CYCLES  = 1000000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           manual_tx,
   input  logic           frame_req,
   tx_scheduler_if.master bus,
   output logic           frame_active,
   output logic           frame_done,
   output logic           tx_timeout,
   output logic           req_dropped
);

   localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int unsigned GCNT_W = $clog2(GAP_CYCLES) + 1;

   if (NWORDS < 2 || NWORDS > (1 << IDX_W) || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 2 ||
       REPEAT_CYCLES < 2 || DATA_W < 1) begin : g_bad_cfg
      $error("tx_scheduler: illegal parameter set");
   end

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP} state_t;

   state_t              state, state_nx;
   logic [IDX_W-1:0]    addr, addr_nx;
   logic [DATA_W-1:0]   data, data_nx;
   logic [TCNT_W-1:0]   tcnt, tcnt_nx;
   logic [GCNT_W-1:0]   gcnt, gcnt_nx;
   logic                pending, pending_nx;
   logic                last, last_nx;
   logic                active_nx, done_nx, to_nx, dropped_nx;
   logic                sync1, sync2, dly;
   logic                req, auto_req, start_frame;

   // Button synchronizer and rising-edge detector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         dly   <= 1'b0;
      end else begin
         sync1 <= manual_tx;
         sync2 <= sync1;
         dly   <= sync2;
      end
   end

`ifdef TX_AUTO_REPEAT_EN
   localparam int unsigned RCNT_W = $clog2(REPEAT_CYCLES) + 1;
   logic [RCNT_W-1:0] rcnt;

   assign auto_req = (rcnt == RCNT_W'(REPEAT_CYCLES - 1));

   // Free-running repeat period, re-aligned to every frame start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          rcnt <= '0;
      else if (start_frame || auto_req) rcnt <= '0;
      else                              rcnt <= rcnt + RCNT_W'(1);
   end
`else
   assign auto_req = 1'b0;
`endif

   assign req          = (sync2 & ~dly) | frame_req | auto_req;
   assign bus.rd_addr  = addr;
   assign bus.tx_data  = data;
   assign bus.tx_start = (state == S_START) && !bus.tx_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         addr         <= '0;
         data         <= '0;
         tcnt         <= '0;
         gcnt         <= '0;
         pending      <= 1'b0;
         last         <= 1'b0;
         frame_active <= 1'b0;
         frame_done   <= 1'b0;
         tx_timeout   <= 1'b0;
         req_dropped  <= 1'b0;
      end else begin
         state        <= state_nx;
         addr         <= addr_nx;
         data         <= data_nx;
         tcnt         <= tcnt_nx;
         gcnt         <= gcnt_nx;
         pending      <= pending_nx;
         last         <= last_nx;
         frame_active <= active_nx;
         frame_done   <= done_nx;
         tx_timeout   <= to_nx;
         req_dropped  <= dropped_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      addr_nx     = addr;
      data_nx     = data;
      tcnt_nx     = tcnt;
      gcnt_nx     = gcnt;
      pending_nx  = pending;
      last_nx     = last;
      active_nx   = frame_active;
      done_nx     = 1'b0;
      to_nx       = 1'b0;
      dropped_nx  = req_dropped;
      start_frame = 1'b0;

      // One pending slot; a request arriving while it is full is lost.
      if (req && frame_active) begin
         if (pending) dropped_nx = 1'b1;
         else         pending_nx = 1'b1;
      end

      case (state)
         S_IDLE: begin
            addr_nx = '0;
            if (req || pending) begin
               state_nx    = S_LOAD;
               pending_nx  = 1'b0;
               active_nx   = 1'b1;
               last_nx     = 1'b0;
               start_frame = 1'b1;
            end
         end
         S_LOAD: begin
            data_nx  = bus.rd_data;
            state_nx = S_START;
         end
         S_START: begin
            if (!bus.tx_busy) begin
               state_nx = S_WAIT;
               tcnt_nx  = '0;
            end
         end
         S_WAIT: begin
            // tx_done has priority; timeout fires on the edge the counter would reach TIMEOUT_CYCLES-1.
            if (bus.tx_done) begin
               state_nx = S_GAP;
               gcnt_nx  = '0;
               if (addr == IDX_W'(NWORDS - 1)) begin
                  done_nx = 1'b1;
                  last_nx = 1'b1;
               end else begin
                  addr_nx = addr + IDX_W'(1);
               end
            end else if (tcnt == TCNT_W'(TIMEOUT_CYCLES - 2)) begin
               to_nx     = 1'b1;
               state_nx  = S_IDLE;
               active_nx = 1'b0;
               addr_nx   = '0;
            end else begin
               tcnt_nx = tcnt + TCNT_W'(1);
            end
         end
         S_GAP: begin
            if (gcnt == GCNT_W'(GAP_CYCLES - 1)) begin
               gcnt_nx = '0;
               if (last) begin
                  state_nx  = S_IDLE;
                  active_nx = 1'b0;
                  addr_nx   = '0;
                  last_nx   = 1'b0;
               end else begin
                  state_nx = S_LOAD;
               end
            end else begin
               gcnt_nx = gcnt + GCNT_W'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_tx_scheduler.sv
// Scoreboard bench for tx_scheduler: expected word/done/timeout events are queued by stimulus
// and popped by an independent monitor.
`timescale 1ns/1ps
module tb_tx_scheduler;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned NWORDS = 16;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned GAP    = 4;
   localparam int unsigned TMO    = 64;
   localparam int unsigned REP    = 200;
   localparam int K_WORD = 0;
   localparam int K_DONE = 1;
   localparam int K_TMO  = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic manual_tx = 1'b0;
   logic frame_req = 1'b0;
   logic frame_active, frame_done, tx_timeout, req_dropped;

   tx_scheduler_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus();

   tx_scheduler #(
      .DATA_W(DATA_W), .NWORDS(NWORDS), .IDX_W(IDX_W), .GAP_CYCLES(GAP),
      .TIMEOUT_CYCLES(TMO), .REPEAT_CYCLES(REP)
   ) dut (
      .clk(clk), .rst(rst), .manual_tx(manual_tx), .frame_req(frame_req), .bus(bus),
      .frame_active(frame_active), .frame_done(frame_done), .tx_timeout(tx_timeout),
      .req_dropped(req_dropped)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] tbl(input logic [3:0] i);
      return 8'(8'h3C + 8'(i) * 8'h11);
   endfunction

   assign bus.rd_data = tbl(bus.rd_addr);

   int   total = 0, bad = 0;
   int   starts = 0, rises = 0, cyc = 0, last_start_cyc = 0;
   int   kill_addr = -1;
   int   rise_cyc[$];
   ev_t  exp_q[$];
   logic prev_active = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_ev(input int kind, input logic [7:0] d);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL event: got kind %0d data %0h, expected none", kind, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.data !== d) begin
            bad++;
            $display("FAIL event: got kind %0d data %0h, expected kind %0d data %0h",
                     kind, d, e.kind, e.data);
         end
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: every observable output event must match the head of the expectation queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.tx_start) begin
            starts++;
            last_start_cyc = cyc;
            check_ev(K_WORD, bus.tx_data);
         end
         if (frame_done) check_ev(K_DONE, 8'h00);
         if (tx_timeout) check_ev(K_TMO, 8'h00);
         if (frame_active && !prev_active) begin
            rises++;
            rise_cyc.push_back(cyc);
         end
      end
      prev_active = frame_active;
   end

   // Transmitter model: tx_done three cycles after each tx_start unless the word is killed.
   initial begin
      bus.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && bus.tx_start && int'(bus.rd_addr) != kill_addr) begin
            repeat (3) @(posedge clk);
            #1 bus.tx_done = 1'b1;
            @(posedge clk);
            #1 bus.tx_done = 1'b0;
         end
      end
   end

   task automatic push_ev(input int kind, input logic [7:0] d);
      ev_t e;
      e.kind = kind;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic push_frame();
      for (int i = 0; i < NWORDS; i++) push_ev(K_WORD, tbl(4'(i)));
      push_ev(K_DONE, 8'h00);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      manual_tx = 1'b0;
      frame_req = 1'b0;
      bus.tx_busy = 1'b0;
      kill_addr = -1;
      exp_q.delete();
      @(negedge clk);
      chk("rst_rd_addr", 32'(bus.rd_addr), 0);
      chk("rst_tx_data", 32'(bus.tx_data), 0);
      chk("rst_tx_start", 32'(bus.tx_start), 0);
      chk("rst_frame_active", 32'(frame_active), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_tx_timeout", 32'(tx_timeout), 0);
      chk("rst_req_dropped", 32'(req_dropped), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      rises = 0;
      starts = 0;
      rise_cyc.delete();
   endtask

   task automatic pulse_req();
      @(posedge clk);
      #1 frame_req = 1'b1;
      @(posedge clk);
      #1 frame_req = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || frame_active) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         total++;
         bad++;
         $display("FAIL %s: timed out after %0d cycles, %0d events outstanding", name, n, exp_q.size());
      end else begin
         chk(name, 32'(exp_q.size()), 0);
      end
   endtask

   initial begin
      int n;
      int seen;
      int s0;
      bus.tx_busy = 1'b0;

`ifdef TX_AUTO_REPEAT_EN
      do_reset();
      repeat (3) push_frame();
      repeat (780) @(negedge clk);
      chk("auto_frames", 32'(rises), 3);
      if (rise_cyc.size() >= 3) begin
         chk("auto_period_1", 32'(rise_cyc[1] - rise_cyc[0]), REP);
         chk("auto_period_2", 32'(rise_cyc[2] - rise_cyc[1]), REP);
      end
      chk("auto_queue", 32'(exp_q.size()), 0);
`else
      // Single frame and its start latency.
      do_reset();
      push_frame();
      pulse_req();
      @(negedge clk);
      chk("lat_active_t1", 32'(frame_active), 1);
      chk("lat_nostart_t1", 32'(bus.tx_start), 0);
      @(negedge clk);
      chk("lat_start_t2", 32'(bus.tx_start), 1);
      chk("lat_data_t2", 32'(bus.tx_data), 32'(tbl(4'd0)));
      wait_idle("frame1_idle", 400);
      chk("frame1_starts", 32'(starts), NWORDS);
      chk("frame1_rises", 32'(rises), 1);
      chk("frame1_active_low", 32'(frame_active), 0);

      // tx_busy holds off the first start.
      do_reset();
      push_frame();
      bus.tx_busy = 1'b1;
      pulse_req();
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.tx_start) seen++;
      end
      chk("busy_withheld", 32'(seen), 0);
      chk("busy_tx_data", 32'(bus.tx_data), 32'(tbl(4'd0)));
      @(posedge clk);
      #1 bus.tx_busy = 1'b0;
      @(negedge clk);
      chk("busy_release_start", 32'(bus.tx_start), 1);
      chk("busy_release_data", 32'(bus.tx_data), 32'(tbl(4'd0)));
      wait_idle("busy_idle", 400);

      // Pending slot: one extra frame, third request dropped.
      do_reset();
      push_frame();
      push_frame();
      pulse_req();
      repeat (20) @(posedge clk);
      pulse_req();
      repeat (20) @(posedge clk);
      chk("pend_not_dropped_yet", 32'(req_dropped), 0);
      pulse_req();
      wait_idle("pend_idle", 800);
      chk("pend_dropped", 32'(req_dropped), 1);
      chk("pend_rises", 32'(rises), 2);
      chk("pend_starts", 32'(starts), 2 * NWORDS);

      // Request in the frame_done cycle goes to pending.
      do_reset();
      push_frame();
      push_frame();
      pulse_req();
      n = 0;
      while (!frame_done && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("fd_seen", 32'(frame_done), 1);
      frame_req = 1'b1;
      @(posedge clk);
      #1 frame_req = 1'b0;
      wait_idle("fd_req_idle", 600);
      chk("fd_req_rises", 32'(rises), 2);
      chk("fd_req_dropped", 32'(req_dropped), 0);

      // Missing tx_done on word 5 times out.
      do_reset();
      kill_addr = 5;
      for (int i = 0; i < 6; i++) push_ev(K_WORD, tbl(4'(i)));
      push_ev(K_TMO, 8'h00);
      pulse_req();
      n = 0;
      while (!tx_timeout && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_seen", 32'(tx_timeout), 1);
      chk("tmo_latency", 32'(cyc - last_start_cyc), TMO);
      chk("tmo_rd_addr", 32'(bus.rd_addr), 0);
      chk("tmo_active", 32'(frame_active), 0);
      kill_addr = -1;
      repeat (20) @(negedge clk);
      chk("tmo_no_restart", 32'(starts), 6);
      wait_idle("tmo_idle", 50);

      // Reset in the middle of a frame.
      do_reset();
      push_frame();
      pulse_req();
      n = 0;
      while (bus.rd_addr != 4'd2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("mid_rd_addr_reached", 32'(bus.rd_addr), 2);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_active", 32'(frame_active), 0);
      chk("mid_rst_start", 32'(bus.tx_start), 0);
      chk("mid_rst_rd_addr", 32'(bus.rd_addr), 0);
      chk("mid_rst_tx_data", 32'(bus.tx_data), 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      s0 = starts;
      repeat (60) @(negedge clk);
      chk("mid_no_start_after", 32'(starts - s0), 0);

      // Bouncing button: two synchronized rises, long level hold adds nothing.
      do_reset();
      push_frame();
      push_frame();
      @(posedge clk);
      #1 manual_tx = 1'b1;
      @(posedge clk);
      #1 manual_tx = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 manual_tx = 1'b1;
      repeat (1000) @(posedge clk);
      #1 manual_tx = 1'b0;
      wait_idle("man_idle", 100);
      chk("man_rises", 32'(rises), 2);
      chk("man_dropped", 32'(req_dropped), 0);

      // No auto-repeat without the option.
      do_reset();
      repeat (500) @(negedge clk);
      chk("noauto_rises", 32'(rises), 0);
      chk("noauto_starts", 32'(starts), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/tx_scheduler.md
# tx_scheduler

Frame-level transmit scheduler for the DAVIS240C configuration path. Arbitrates transmit requests from a manual push-button, a logic-side frame request and an optional auto-repeat timer. Sequences one frame of NWORDS words from an external word table into the downstream word transmitter over a start/busy/done handshake, with a programmable inter-word gap and a per-word timeout. Sits between the request sources and the serial transmitter, replacing ad-hoc new-transmission pulse generation.

## Interface
- DATA_W, 8, transmitter word width
- NWORDS, 16, words per frame (2..2^IDX_W)
- IDX_W, 4, word-index width
- GAP_CYCLES, 4, idle cycles between words (>=1)
- TIMEOUT_CYCLES, 65536, max cycles waiting for tx_done per word
- REPEAT_CYCLES, 1000000, auto-repeat period (used only with TX_AUTO_REPEAT_EN)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- manual_tx  in  1  asynchronous button level; rising edge requests a frame
- frame_req  in  1  synchronous one-cycle frame request
- tx_busy  in  1  transmitter busy; blocks tx_start
- tx_done  in  1  one-cycle pulse, current word finished
- rd_data  in  DATA_W  word-table read data, combinational on rd_addr
- rd_addr  out  IDX_W  word-table index of current word
- tx_data  out  DATA_W  registered word to transmit
- tx_start  out  1  one-cycle start strobe to transmitter
- frame_active  out  1  high from frame start until return to IDLE
- frame_done  out  1  one-cycle pulse, last word's tx_done accepted
- tx_timeout  out  1  one-cycle pulse, word aborted on timeout
- req_dropped  out  1  sticky: request lost because pending slot full

## Operation
- manual_tx: 2-FF synchronizer plus one delay register; request = sync & !delayed.
- Request = manual edge | frame_req | auto request; simultaneous sources coalesce into one.
- Request in IDLE starts a frame. Request while frame_active sets pending; request while pending already set sets req_dropped (cleared only by rst).
- FSM states: IDLE, LOAD, START, WAIT, GAP.
- IDLE: rd_addr=0; on request or pending -> LOAD, clear pending, frame_active<=1.
- LOAD: tx_data<=rd_data -> START.
- START: tx_start = (state==START) & !tx_busy; when asserted -> WAIT, clear timeout counter. Else hold.
- WAIT: tx_done -> GAP; if rd_addr==NWORDS-1 pulse frame_done and mark last, else rd_addr<=rd_addr+1. Timeout counter reaching TIMEOUT_CYCLES-1 -> pulse tx_timeout, go IDLE, frame_active<=0, rd_addr<=0; pending preserved.
- GAP: count GAP_CYCLES cycles; then LOAD if not last, else IDLE with frame_active<=0.
- tx_done outside WAIT ignored. tx_done and timeout terminal count in same cycle: tx_done wins.
- Counters sized ceil(log2(N))+1 bits; no wrap inside a frame.

## Timing
- Reset values: state IDLE, rd_addr 0, tx_data 0, tx_start 0, frame_active 0, frame_done 0, tx_timeout 0, req_dropped 0, pending 0, sync/delay regs 0, all counters 0.
- frame_req at cycle T (IDLE, tx_busy=0): LOAD at T+1, frame_active high from T+1, tx_data valid and tx_start high at T+2.
- manual_tx rise before edge T: request at T+2, tx_start at T+4.
- tx_done at cycle D (not last): rd_addr increments at D+1, next tx_start at D+GAP_CYCLES+2.
- Last word: frame_done high in cycle D+1; frame_active low from D+GAP_CYCLES+1; pending frame then restarts LOAD next cycle.
- Request in same cycle as frame_done: goes to pending.
- rst mid-frame: all outputs return to reset values immediately; no tx_start after release until new request.

## Configuration
- TX_AUTO_REPEAT_EN defined: REPEAT_CYCLES counter increments every cycle, clears on each frame start; at REPEAT_CYCLES-1 issues one-cycle auto request and wraps to 0.
- Undefined: no timer logic, auto request tied 0, REPEAT_CYCLES ignored.

## Test plan
- Reset, frame_req at T, tx_busy=0, tx_done 3 cycles after each tx_start, NWORDS=16 -> 16 tx_start pulses, tx_data = table[0..15] in order, one frame_done, frame_active low afterward.
- tx_busy held high 10 cycles at START -> tx_start withheld, asserted first cycle tx_busy low, tx_data unchanged.
- Two frame_req pulses during frame, third during same frame -> exactly one extra frame back-to-back, req_dropped=1.
- No tx_done after word 5 -> tx_timeout at tx_start+TIMEOUT_CYCLES, rd_addr=0, state IDLE, frame_active=0.
- manual_tx held high 1000 cycles with 5-cycle bounce at rise -> frame started per synchronized rising edge; level hold gives no extra frames.
- With TX_AUTO_REPEAT_EN, REPEAT_CYCLES=200, no other requests -> frame starts every 200 cycles; without macro -> no frames.
